pkt_classifier: RTL and testbench

//  Parametrised successor of the RMT ingress packet filter. Sits between the MAC-side AXIS input and the parser/control path.

---
 rtl/pkt_classifier.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_pkt_classifier.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_classifier.sv
// Ingress packet classifier: steers IPv4/UDP control traffic to the control output, everything else
// to the data output or drops it, behind one fall-through FIFO with per-class packet counters.
module pkt_classifier #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH_BITS      = 5,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
    output logic                              ctrl_m_axis_tvalid,
    output logic                              ctrl_m_axis_tlast,
    input  logic                              ctrl_m_axis_tready,

    input  logic [15:0]                       cfg_ctrl_port,
    input  logic                              cfg_drop_non_udp,

    input  logic                              stat_clear,
    output logic [CNT_WIDTH-1:0]              stat_data_pkts,
    output logic [CNT_WIDTH-1:0]              stat_ctrl_pkts,
    output logic [CNT_WIDTH-1:0]              stat_drop_pkts
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int TW    = C_S_AXIS_TUSER_WIDTH;
    localparam int EW    = DW + KW + TW + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE   = {{(FIFO_DEPTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE   = {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_BITS:0]   NF_LEVEL  = (FIFO_DEPTH_BITS+1)'(DEPTH - 2);
    localparam logic [CNT_WIDTH-1:0]       STAT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]       STAT_ZERO = {CNT_WIDTH{1'b0}};

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [TW-1:0] user;
        logic          last;
    } beat_t;

    localparam beat_t BEAT_ZERO = {EW{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOLD      = 3'd1,
        S_EMIT      = 3'd2,
        S_FWD       = 3'd3,
        S_DROP      = 3'd4,
        S_DROP_DONE = 3'd5
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (&value) ? value : (value + STAT_ONE);
    endfunction

    // ---------------- input FIFO ----------------
    beat_t                      fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_r;
    logic [FIFO_DEPTH_BITS:0]   count_r;
    logic                       wr_en_s;
    logic                       pop_s;
    logic                       head_valid_s;
    beat_t                      head_s;
    beat_t                      in_beat_s;

    assign s_axis_tready = (count_r < NF_LEVEL);
    assign wr_en_s       = s_axis_tvalid & s_axis_tready;
    assign head_valid_s  = (count_r != {(FIFO_DEPTH_BITS+1){1'b0}});
    assign head_s        = fifo_mem[rd_ptr_r];
    assign in_beat_s     = '{data: s_axis_tdata, keep: s_axis_tkeep, user: s_axis_tuser, last: s_axis_tlast};

    // FIFO storage write port (no reset: contents are qualified by count_r)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            fifo_mem[wr_ptr_r] <= in_beat_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r <= {FIFO_DEPTH_BITS{1'b0}};
            rd_ptr_r <= {FIFO_DEPTH_BITS{1'b0}};
            count_r  <= {(FIFO_DEPTH_BITS+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // ---------------- classification FSM ----------------
    state_t state_r;
    state_t state_nxt_s;
    beat_t  hold_r;
    logic   dest_r;             // 1: control output, 0: data output
    logic   dest_nxt_s;
    logic   dest_load_s;
    logic   hold_load_s;
    logic   out_load_s;
    logic   out_from_hold_s;
    logic   drop_inc_s;
    logic   dest_free_s;
    logic   is_udp_s;
    logic   m_valid_r;
    logic   c_valid_r;
    beat_t  m_r;
    beat_t  c_r;
    beat_t  out_beat_s;

    assign is_udp_s    = (head_s.data[143:128] == 16'h0008) && (head_s.data[223:216] == 8'h11);
    assign dest_free_s = dest_r ? (!c_valid_r || ctrl_m_axis_tready) : (!m_valid_r || m_axis_tready);
    assign out_beat_s  = out_from_hold_s ? hold_r : head_s;

    // State, hold register and destination register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= S_IDLE;
            hold_r  <= BEAT_ZERO;
            dest_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (hold_load_s) begin
                hold_r <= head_s;
            end
            if (dest_load_s) begin
                dest_r <= dest_nxt_s;
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt_s     = state_r;
        pop_s           = 1'b0;
        hold_load_s     = 1'b0;
        dest_load_s     = 1'b0;
        dest_nxt_s      = dest_r;
        out_load_s      = 1'b0;
        out_from_hold_s = 1'b0;
        drop_inc_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (head_valid_s) begin
                    pop_s       = 1'b1;
                    hold_load_s = 1'b1;
                    if (is_udp_s) begin
                        state_nxt_s = head_s.last ? S_DROP_DONE : S_HOLD;
                    end else if (cfg_drop_non_udp) begin
                        state_nxt_s = head_s.last ? S_DROP_DONE : S_DROP;
                    end else begin
                        dest_load_s = 1'b1;
                        dest_nxt_s  = 1'b0;
                        state_nxt_s = S_EMIT;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_HOLD: begin
                // beat1 is inspected in place; it is forwarded later from the FIFO head
                if (head_valid_s) begin
                    dest_load_s = 1'b1;
                    dest_nxt_s  = (head_s.data[79:64] == cfg_ctrl_port);
                    state_nxt_s = S_EMIT;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_EMIT: begin
                if (dest_free_s) begin
                    out_load_s      = 1'b1;
                    out_from_hold_s = 1'b1;
                    state_nxt_s     = hold_r.last ? S_IDLE : S_FWD;
                end else begin
                    state_nxt_s = S_EMIT;
                end
            end
            S_FWD: begin
                if (dest_free_s && head_valid_s) begin
                    pop_s       = 1'b1;
                    out_load_s  = 1'b1;
                    state_nxt_s = head_s.last ? S_IDLE : S_FWD;
                end else begin
                    state_nxt_s = S_FWD;
                end
            end
            S_DROP: begin
                if (head_valid_s) begin
                    pop_s       = 1'b1;
                    drop_inc_s  = head_s.last;
                    state_nxt_s = head_s.last ? S_IDLE : S_DROP;
                end else begin
                    state_nxt_s = S_DROP;
                end
            end
            S_DROP_DONE: begin
                drop_inc_s  = 1'b1;
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // ---------------- output registers ----------------
    // Data-path output register: payload only changes on a load, which requires the register to be free
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_r       <= BEAT_ZERO;
            m_valid_r <= 1'b0;
        end else if (out_load_s && !dest_r) begin
            m_r       <= out_beat_s;
            m_valid_r <= 1'b1;
        end else if (m_axis_tready) begin
            m_valid_r <= 1'b0;
        end
    end

    // Control-path output register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            c_r       <= BEAT_ZERO;
            c_valid_r <= 1'b0;
        end else if (out_load_s && dest_r) begin
            c_r       <= out_beat_s;
            c_valid_r <= 1'b1;
        end else if (ctrl_m_axis_tready) begin
            c_valid_r <= 1'b0;
        end
    end

    assign m_axis_tdata       = m_r.data;
    assign m_axis_tkeep       = m_r.keep;
    assign m_axis_tuser       = m_r.user;
    assign m_axis_tlast       = m_r.last;
    assign m_axis_tvalid      = m_valid_r;
    assign ctrl_m_axis_tdata  = c_r.data;
    assign ctrl_m_axis_tkeep  = c_r.keep;
    assign ctrl_m_axis_tuser  = c_r.user;
    assign ctrl_m_axis_tlast  = c_r.last;
    assign ctrl_m_axis_tvalid = c_valid_r;

    // ---------------- statistics ----------------
    logic [CNT_WIDTH-1:0] data_cnt_r;
    logic [CNT_WIDTH-1:0] ctrl_cnt_r;
    logic [CNT_WIDTH-1:0] drop_cnt_r;
    logic                 data_inc_s;
    logic                 ctrl_inc_s;

    assign data_inc_s = m_valid_r & m_axis_tready & m_r.last;
    assign ctrl_inc_s = c_valid_r & ctrl_m_axis_tready & c_r.last;

    // Saturating per-class packet counters; a clear overrides a same-cycle increment
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            data_cnt_r <= STAT_ZERO;
            ctrl_cnt_r <= STAT_ZERO;
            drop_cnt_r <= STAT_ZERO;
        end else if (stat_clear) begin
            data_cnt_r <= STAT_ZERO;
            ctrl_cnt_r <= STAT_ZERO;
            drop_cnt_r <= STAT_ZERO;
        end else begin
            if (data_inc_s) begin
                data_cnt_r <= sat_inc(data_cnt_r);
            end
            if (ctrl_inc_s) begin
                ctrl_cnt_r <= sat_inc(ctrl_cnt_r);
            end
            if (drop_inc_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    assign stat_data_pkts = data_cnt_r;
    assign stat_ctrl_pkts = ctrl_cnt_r;
    assign stat_drop_pkts = drop_cnt_r;

endmodule

// File: tb/tb_pkt_classifier.sv
// Scoreboard bench for pkt_classifier: directed packets push expected beats per output,
// a monitor pops and compares on every output handshake.
module tb_pkt_classifier;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic         clk;
    logic         aresetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [255:0] ctrl_m_axis_tdata;
    logic [31:0]  ctrl_m_axis_tkeep;
    logic [127:0] ctrl_m_axis_tuser;
    logic         ctrl_m_axis_tvalid;
    logic         ctrl_m_axis_tlast;
    logic         ctrl_m_axis_tready;
    logic [15:0]  cfg_ctrl_port;
    logic         cfg_drop_non_udp;
    logic         stat_clear;
    logic [31:0]  stat_data_pkts;
    logic [31:0]  stat_ctrl_pkts;
    logic [31:0]  stat_drop_pkts;

    pkt_classifier #(
        .C_S_AXIS_DATA_WIDTH (256),
        .C_S_AXIS_TUSER_WIDTH(128),
        .FIFO_DEPTH_BITS     (5),
        .CNT_WIDTH           (32)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .ctrl_m_axis_tdata (ctrl_m_axis_tdata),
        .ctrl_m_axis_tkeep (ctrl_m_axis_tkeep),
        .ctrl_m_axis_tuser (ctrl_m_axis_tuser),
        .ctrl_m_axis_tvalid(ctrl_m_axis_tvalid),
        .ctrl_m_axis_tlast (ctrl_m_axis_tlast),
        .ctrl_m_axis_tready(ctrl_m_axis_tready),
        .cfg_ctrl_port     (cfg_ctrl_port),
        .cfg_drop_non_udp  (cfg_drop_non_udp),
        .stat_clear        (stat_clear),
        .stat_data_pkts    (stat_data_pkts),
        .stat_ctrl_pkts    (stat_ctrl_pkts),
        .stat_drop_pkts    (stat_drop_pkts)
    );

    localparam int DEST_DATA = 0;
    localparam int DEST_CTRL = 1;
    localparam int DEST_DROP = 2;

    beat_t exp_m[$];
    beat_t exp_c[$];
    int    total;
    int    bad;
    int    exp_data_cnt;
    int    exp_ctrl_cnt;
    int    exp_drop_cnt;
    bit    saw_full;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic beat_t mk_beat(input int id, input int idx, input int n, input bit udp,
                                      input logic [15:0] port);
        beat_t       b;
        logic [7:0]  idb;
        logic [7:0]  ixb;
        logic [31:0] uid;
        idb = id[7:0];
        ixb = idx[7:0];
        uid = id * 16 + idx;
        b.data = {8{idb, ixb, 16'hA5C3}};
        if (idx == 0) begin
            b.data[143:128] = udp ? 16'h0008 : 16'h0608;
            b.data[223:216] = udp ? 8'h11 : 8'h06;
        end
        if (idx == 1) begin
            b.data[79:64] = port;
        end
        b.last = (idx == n - 1);
        b.keep = b.last ? 32'h0000_ffff : 32'hffff_ffff;
        b.user = {4{uid}};
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string name);
        chk({name, "_data_cnt"}, {224'd0, stat_data_pkts}, exp_data_cnt);
        chk({name, "_ctrl_cnt"}, {224'd0, stat_ctrl_pkts}, exp_ctrl_cnt);
        chk({name, "_drop_cnt"}, {224'd0, stat_drop_pkts}, exp_drop_cnt);
    endtask

    task automatic send_pkt(input int id, input int n, input bit udp, input logic [15:0] port,
                            input int dest);
        beat_t b;
        int    guard;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(id, i, n, udp, port);
            if (dest == DEST_DATA) exp_m.push_back(b);
            else if (dest == DEST_CTRL) exp_c.push_back(b);
            s_axis_tdata  = b.data;
            s_axis_tkeep  = b.keep;
            s_axis_tuser  = b.user;
            s_axis_tlast  = b.last;
            s_axis_tvalid = 1'b1;
            guard = 0;
            @(negedge clk);
            while (!s_axis_tready && guard < 5000) begin
                guard++;
                @(negedge clk);
            end
            if (guard >= 5000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: s_axis_tready stayed 0 for pkt %0d beat %0d", id, i);
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((exp_m.size() != 0 || exp_c.size() != 0) && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s_drain: %0d data / %0d ctrl beats still expected", name,
                     exp_m.size(), exp_c.size());
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        beat_t act;
        beat_t exp_b;
        beat_t b0;
        int    guard;
        bit    toggle_done;

        total = 0; bad = 0;
        exp_data_cnt = 0; exp_ctrl_cnt = 0; exp_drop_cnt = 0;
        saw_full = 1'b0;
        aresetn = 1'b0;
        s_axis_tdata = 256'd0; s_axis_tkeep = 32'd0; s_axis_tuser = 128'd0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1; ctrl_m_axis_tready = 1'b1;
        cfg_ctrl_port = 16'hf2f1; cfg_drop_non_udp = 1'b0; stat_clear = 1'b0;

        #1;
        chk("reset_m_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        chk("reset_ctrl_tvalid", {255'd0, ctrl_m_axis_tvalid}, 256'd0);
        check_stats("reset");
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;

        fork
            // monitor: pop and compare on every output handshake
            forever begin
                @(negedge clk);
                if (aresetn) begin
                    if (s_axis_tvalid && !s_axis_tready) saw_full = 1'b1;
                    if (m_axis_tvalid && m_axis_tready) begin
                        act = '{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser, last: m_axis_tlast};
                        total++;
                        if (exp_m.size() == 0) begin
                            bad++;
                            $display("FAIL m_unexpected: got data=%h last=%b, expected no beat", act.data, act.last);
                        end else begin
                            exp_b = exp_m.pop_front();
                            if (act !== exp_b) begin
                                bad++;
                                $display("FAIL m_beat: got data=%h keep=%h user=%h last=%b expected data=%h keep=%h user=%h last=%b",
                                         act.data, act.keep, act.user, act.last, exp_b.data, exp_b.keep, exp_b.user, exp_b.last);
                            end
                        end
                    end
                    if (ctrl_m_axis_tvalid && ctrl_m_axis_tready) begin
                        act = '{data: ctrl_m_axis_tdata, keep: ctrl_m_axis_tkeep, user: ctrl_m_axis_tuser, last: ctrl_m_axis_tlast};
                        total++;
                        if (exp_c.size() == 0) begin
                            bad++;
                            $display("FAIL ctrl_unexpected: got data=%h last=%b, expected no beat", act.data, act.last);
                        end else begin
                            exp_b = exp_c.pop_front();
                            if (act !== exp_b) begin
                                bad++;
                                $display("FAIL ctrl_beat: got data=%h keep=%h user=%h last=%b expected data=%h keep=%h user=%h last=%b",
                                         act.data, act.keep, act.user, act.last, exp_b.data, exp_b.keep, exp_b.user, exp_b.last);
                            end
                        end
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        @(posedge clk); #1;

        // 1: UDP to a non-control port goes to the data path
        send_pkt(1, 2, 1'b1, 16'h1234, DEST_DATA);
        exp_data_cnt = 1;
        drain("t1");
        check_stats("t1");

        // 2: control packet with the control output stalled for 10 cycles
        ctrl_m_axis_tready = 1'b0;
        send_pkt(2, 2, 1'b1, 16'hf2f1, DEST_CTRL);
        b0 = mk_beat(2, 0, 2, 1'b1, 16'hf2f1);
        guard = 0;
        @(negedge clk);
        while (!ctrl_m_axis_tvalid && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            chk("t2_stall_valid", {255'd0, ctrl_m_axis_tvalid}, 256'd1);
            chk("t2_stall_data", ctrl_m_axis_tdata, b0.data);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ctrl_m_axis_tready = 1'b1;
        exp_ctrl_cnt = 1;
        drain("t2");
        check_stats("t2");

        // 3a: non-IPv4 packet dropped
        cfg_drop_non_udp = 1'b1;
        send_pkt(3, 3, 1'b0, 16'h0000, DEST_DROP);
        exp_drop_cnt = 1;
        drain("t3a");
        check_stats("t3a");

        // 3b: non-IPv4 packet forwarded
        cfg_drop_non_udp = 1'b0;
        send_pkt(4, 3, 1'b0, 16'h0000, DEST_DATA);
        exp_data_cnt = 2;
        drain("t3b");
        check_stats("t3b");

        // 4: single-beat UDP runt followed by a normal packet
        send_pkt(5, 1, 1'b1, 16'h0000, DEST_DROP);
        send_pkt(6, 2, 1'b1, 16'h1234, DEST_DATA);
        exp_drop_cnt = 2;
        exp_data_cnt = 3;
        drain("t4");
        check_stats("t4");

        // counter clear
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        exp_data_cnt = 0; exp_ctrl_cnt = 0; exp_drop_cnt = 0;
        check_stats("clear");

        // 5: 40 back-to-back 4-beat packets with m_axis_tready toggling
        saw_full = 1'b0;
        toggle_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    send_pkt(10 + p, 4, p[0] == 1'b0, 16'h1234, DEST_DATA);
                end
                drain("t5");
                toggle_done = 1'b1;
            end
            begin
                while (!toggle_done) begin
                    @(posedge clk);
                    #1 m_axis_tready = ~m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        exp_data_cnt = 40;
        check_stats("t5");
        chk("t5_tready_backpressure", {255'd0, saw_full}, 256'd1);

        // 6: reset while forwarding, then a fresh control packet
        m_axis_tready = 1'b0;
        send_pkt(60, 4, 1'b1, 16'h1234, DEST_DATA);
        guard = 0;
        @(negedge clk);
        while (!m_axis_tvalid && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        aresetn = 1'b0;
        #1;
        exp_m.delete();
        exp_c.delete();
        exp_data_cnt = 0; exp_ctrl_cnt = 0; exp_drop_cnt = 0;
        chk("t6_rst_m_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        chk("t6_rst_m_tdata", m_axis_tdata, 256'd0);
        chk("t6_rst_ctrl_tvalid", {255'd0, ctrl_m_axis_tvalid}, 256'd0);
        check_stats("t6_rst");
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        send_pkt(61, 3, 1'b1, 16'hf2f1, DEST_CTRL);
        exp_ctrl_cnt = 1;
        drain("t6");
        check_stats("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
